// File: rtl/me_stage.sv
// Memory-access pipeline stage: holds one instruction from EX, waits for the data SRAM
// response when a request was issued, aligns load data and hands the result to WB.
module me_stage (
  input  logic        clk,
  input  logic        resetn,
  input  logic        EX_to_ME_Valid,
  input  logic [74:0] EX_to_ME_Bus,
  output logic        ME_Allow_in,
  input  logic        WB_Allow_in,
  output logic        ME_to_WB_Valid,
  output logic [69:0] ME_to_WB_Bus,
  input  logic        data_sram_data_ok,
  input  logic [31:0] data_sram_rdata,
  output logic [4:0]  ME_dest,
  output logic [31:0] ME_Forward_Res,
  output logic        ME_Load_Busy
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned OP_W   = 3;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  localparam logic [OP_W-1:0] OP_LD_B  = 3'b000;
  localparam logic [OP_W-1:0] OP_LD_H  = 3'b001;
  localparam logic [OP_W-1:0] OP_LD_BU = 3'b100;
  localparam logic [OP_W-1:0] OP_LD_HU = 3'b101;

  logic [1:0]        state_q, state_d;
  logic              me_valid_q;
  logic [DATA_W-1:0] hold_q, hold_d;

  logic [DATA_W-1:0] pc_q;
  logic              gr_we_q;
  logic [REG_W-1:0]  dest_q;
  logic [DATA_W-1:0] alu_result_q;
  logic              res_from_mem_q;
  logic [OP_W-1:0]   mem_op_q;
  logic              mem_req_q;

  logic              me_ready_go;
  logic              accept;
  logic              leave;
  logic              in_mem_req;
  logic [DATA_W-1:0] load_word;
  logic [7:0]        load_byte;
  logic [15:0]       load_half;
  logic [DATA_W-1:0] load_result;
  logic [DATA_W-1:0] final_result;

  assign in_mem_req = EX_to_ME_Bus[0];

  // Handshake: ME may proceed once its memory response (if any) is in hand.
  assign me_ready_go = (me_valid_q && !mem_req_q)
                     || (state_q == WAIT && data_sram_data_ok)
                     || (state_q == HOLD);
  assign ME_Allow_in    = !me_valid_q || (me_ready_go && WB_Allow_in);
  assign ME_to_WB_Valid = me_valid_q && me_ready_go;
  assign accept         = EX_to_ME_Valid && ME_Allow_in;
  assign leave          = me_valid_q && me_ready_go && WB_Allow_in;

  // Next-state and hold-buffer capture for the outstanding memory response.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    if (accept) begin
      state_d = in_mem_req ? WAIT : IDLE;
    end else if (leave) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        WAIT: begin
          if (data_sram_data_ok && !WB_Allow_in) begin
            state_d = HOLD;
            hold_d  = data_sram_rdata;
          end
        end
        HOLD:    state_d = HOLD;
        IDLE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      me_valid_q <= 1'b0;
      hold_q     <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      if (ME_Allow_in) begin
        me_valid_q <= EX_to_ME_Valid;
      end
    end
  end

  // Payload registers carry no reset; every consumer is qualified by me_valid_q.
  always_ff @(posedge clk) begin
    if (accept) begin
      pc_q           <= EX_to_ME_Bus[74:43];
      gr_we_q        <= EX_to_ME_Bus[42];
      dest_q         <= EX_to_ME_Bus[41:37];
      alu_result_q   <= EX_to_ME_Bus[36:5];
      res_from_mem_q <= EX_to_ME_Bus[4];
      mem_op_q       <= EX_to_ME_Bus[3:1];
      mem_req_q      <= EX_to_ME_Bus[0];
    end
  end

  // Load alignment: buffered word once parked in HOLD, otherwise the live response.
  always_comb begin
    load_word = (state_q == HOLD) ? hold_q : data_sram_rdata;
    load_byte = load_word[7:0];
    case (alu_result_q[1:0])
      2'b00:   load_byte = load_word[7:0];
      2'b01:   load_byte = load_word[15:8];
      2'b10:   load_byte = load_word[23:16];
      2'b11:   load_byte = load_word[31:24];
      default: load_byte = load_word[7:0];
    endcase
    load_half = alu_result_q[1] ? load_word[31:16] : load_word[15:0];
    case (mem_op_q)
      OP_LD_B:  load_result = {{24{load_byte[7]}}, load_byte};
      OP_LD_H:  load_result = {{16{load_half[15]}}, load_half};
      OP_LD_BU: load_result = {24'd0, load_byte};
      OP_LD_HU: load_result = {16'd0, load_half};
      default:  load_result = load_word;
    endcase
    final_result = res_from_mem_q ? load_result : alu_result_q;
  end

  assign ME_to_WB_Bus   = {pc_q, gr_we_q, dest_q, final_result};
  assign ME_dest        = dest_q & {REG_W{gr_we_q && me_valid_q}};
  assign ME_Forward_Res = final_result;
  assign ME_Load_Busy   = me_valid_q && res_from_mem_q && !me_ready_go;

endmodule

// File: tb/tb_me_stage.sv
// Bench for me_stage: directed scenarios plus random traffic checked every cycle
// against a transaction-level model of the single ME slot.
module tb_me_stage;

  logic        clk = 1'b0;
  logic        resetn;
  logic        ex_valid;
  logic [74:0] ex_bus;
  logic        me_allow_in;
  logic        wb_allow_in;
  logic        to_wb_valid;
  logic [69:0] to_wb_bus;
  logic        data_ok;
  logic [31:0] rdata;
  logic [4:0]  me_dest;
  logic [31:0] fwd_res;
  logic        load_busy;

  int n_vec = 0;
  int n_err = 0;

  // Model of the ME slot: occupant fields, whether its response arrived, and that data.
  logic        m_valid = 1'b0;
  logic        m_done  = 1'b0;
  logic [31:0] m_pc, m_alu, m_data;
  logic        m_gr_we, m_rfm, m_req;
  logic [4:0]  m_dest;
  logic [2:0]  m_op;

  always #5 clk = ~clk;

  me_stage dut (
    .clk               (clk),
    .resetn            (resetn),
    .EX_to_ME_Valid    (ex_valid),
    .EX_to_ME_Bus      (ex_bus),
    .ME_Allow_in       (me_allow_in),
    .WB_Allow_in       (wb_allow_in),
    .ME_to_WB_Valid    (to_wb_valid),
    .ME_to_WB_Bus      (to_wb_bus),
    .data_sram_data_ok (data_ok),
    .data_sram_rdata   (rdata),
    .ME_dest           (me_dest),
    .ME_Forward_Res    (fwd_res),
    .ME_Load_Busy      (load_busy)
  );

  task automatic chk(input string tag, input logic [69:0] got, input logic [69:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [74:0] mk_bus(input logic [31:0] pc, input logic gr_we,
                                         input logic [4:0] dest, input logic [31:0] alu,
                                         input logic rfm, input logic [2:0] op,
                                         input logic req);
    return {pc, gr_we, dest, alu, rfm, op, req};
  endfunction

  // Reference load extraction written with shifts rather than lane selects.
  function automatic logic [31:0] ref_align(input logic [2:0] op, input logic [1:0] a,
                                            input logic [31:0] w);
    logic [31:0] bsh, hsh;
    bsh = w >> (8 * a);
    hsh = w >> (16 * a[1]);
    case (op)
      3'b000:  return 32'($signed(bsh[7:0]));
      3'b001:  return 32'($signed(hsh[15:0]));
      3'b100:  return 32'(bsh[7:0]);
      3'b101:  return 32'(hsh[15:0]);
      default: return w;
    endcase
  endfunction

  function automatic logic outstanding();
    return m_valid && m_req && !m_done;
  endfunction

  // One cycle: check outputs mid-cycle against the model, advance the model, cross the edge.
  task automatic step();
    logic rdy, lv, allow;
    logic [31:0] res;
    @(negedge clk);
    if (!resetn) begin
      m_valid = 1'b0;
      m_done  = 1'b0;
    end
    rdy   = m_valid && (!m_req || m_done || (data_ok && outstanding()));
    lv    = rdy && wb_allow_in;
    allow = !m_valid || lv;
    res   = m_rfm ? ref_align(m_op, m_alu[1:0], m_done ? m_data : rdata) : m_alu;
    chk("allow_in", 70'(me_allow_in), 70'(allow));
    chk("wb_valid", 70'(to_wb_valid), 70'(rdy));
    chk("me_dest", 70'(me_dest), 70'((m_valid && m_gr_we) ? m_dest : 5'd0));
    chk("load_busy", 70'(load_busy), 70'(m_valid && m_rfm && !rdy));
    if (m_valid) chk("fwd_res", 70'(fwd_res), 70'(res));
    if (rdy) chk("wb_bus", to_wb_bus, {m_pc, m_gr_we, m_dest, res});
    if (resetn) begin
      if (allow) begin
        m_valid = ex_valid;
        if (ex_valid) begin
          {m_pc, m_gr_we, m_dest, m_alu, m_rfm, m_op, m_req} = ex_bus;
          m_done = 1'b0;
        end
      end else if (outstanding() && data_ok) begin
        m_done = 1'b1;
        m_data = rdata;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ex_valid = 1'b0;
    data_ok  = 1'b0;
    wb_allow_in = 1'b1;
  endtask

  initial begin
    resetn = 1'b0;
    ex_valid = 1'b0;
    ex_bus = '0;
    wb_allow_in = 1'b1;
    data_ok = 1'b0;
    rdata = '0;
    #1;
    chk("rst_valid", 70'(to_wb_valid), 70'd0);
    chk("rst_busy", 70'(load_busy), 70'd0);
    chk("rst_dest", 70'(me_dest), 70'd0);
    step();
    step();
    resetn = 1'b1;
    step();

    // ALU op passes with one cycle of latency.
    ex_valid = 1'b1;
    ex_bus = mk_bus(32'h1C00_0000, 1'b1, 5'd5, 32'h1234_5678, 1'b0, 3'b010, 1'b0);
    step();
    idle_inputs();
    #1;
    chk("alu_bus", to_wb_bus, {32'h1C00_0000, 1'b1, 5'd5, 32'h1234_5678});
    chk("alu_dest", 70'(me_dest), 70'd5);
    chk("alu_valid", 70'(to_wb_valid), 70'd1);
    step();

    // ld.b at byte 3, response two cycles later.
    ex_valid = 1'b1;
    ex_bus = mk_bus(32'h1C00_0010, 1'b1, 5'd9, 32'h0000_1003, 1'b1, 3'b000, 1'b1);
    step();
    idle_inputs();
    rdata = 32'hDEAD_BEEF;
    #1 chk("ldb_busy1", 70'(load_busy), 70'd1);
    step();
    #1 chk("ldb_busy2", 70'(load_busy), 70'd1);
    step();
    data_ok = 1'b1;
    rdata = 32'h80FF_00AA;
    #1;
    chk("ldb_busy3", 70'(load_busy), 70'd0);
    chk("ldb_res", 70'(fwd_res), 70'h0000_0000_FFFF_FF80);
    step();
    idle_inputs();

    // ld.hu parked in HOLD while WB stalls; later rdata noise must not leak in.
    ex_valid = 1'b1;
    ex_bus = mk_bus(32'h1C00_0020, 1'b1, 5'd3, 32'h0000_2002, 1'b1, 3'b101, 1'b1);
    step();
    idle_inputs();
    data_ok = 1'b1;
    wb_allow_in = 1'b0;
    rdata = 32'h8001_7FFF;
    step();
    data_ok = 1'b0;
    rdata = 32'h1234_ABCD;
    step();
    wb_allow_in = 1'b1;
    rdata = 32'h5555_AAAA;
    #1;
    chk("ldhu_valid", 70'(to_wb_valid), 70'd1);
    chk("ldhu_res", 70'(fwd_res), 70'h0000_0000_0000_8001);
    step();

    // Store: waits for data_ok, never forwards a destination.
    ex_valid = 1'b1;
    ex_bus = mk_bus(32'h1C00_0030, 1'b0, 5'd7, 32'h0000_4444, 1'b0, 3'b010, 1'b1);
    step();
    idle_inputs();
    #1;
    chk("st_wait", 70'(to_wb_valid), 70'd0);
    chk("st_dest", 70'(me_dest), 70'd0);
    step();
    data_ok = 1'b1;
    #1;
    chk("st_res", 70'(fwd_res), 70'h0000_0000_0000_4444);
    chk("st_dest2", 70'(me_dest), 70'd0);
    step();
    idle_inputs();

    // Back-to-back loads: second must wait for its own response.
    ex_valid = 1'b1;
    ex_bus = mk_bus(32'h1C00_0040, 1'b1, 5'd1, 32'h0000_0000, 1'b1, 3'b010, 1'b1);
    step();
    ex_bus = mk_bus(32'h1C00_0044, 1'b1, 5'd2, 32'h0000_0004, 1'b1, 3'b010, 1'b1);
    data_ok = 1'b1;
    rdata = 32'h1111_1111;
    #1 chk("b2b_allow", 70'(me_allow_in), 70'd1);
    step();
    idle_inputs();
    rdata = 32'h2222_2222;
    #1;
    chk("b2b_nouse", 70'(to_wb_valid), 70'd0);
    chk("b2b_busy", 70'(load_busy), 70'd1);
    step();
    data_ok = 1'b1;
    step();
    idle_inputs();

    // Reset in WAIT, then a stray response.
    ex_valid = 1'b1;
    ex_bus = mk_bus(32'h1C00_0050, 1'b1, 5'd4, 32'h0000_0008, 1'b1, 3'b010, 1'b1);
    step();
    idle_inputs();
    step();
    resetn = 1'b0;
    #1;
    chk("rstw_valid", 70'(to_wb_valid), 70'd0);
    chk("rstw_busy", 70'(load_busy), 70'd0);
    chk("rstw_dest", 70'(me_dest), 70'd0);
    step();
    resetn = 1'b1;
    data_ok = 1'b1;
    #1 chk("stray_ok", 70'(to_wb_valid), 70'd0);
    step();
    idle_inputs();
    step();

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      logic req;
      req = 1'($urandom_range(0, 1));
      ex_valid = ($urandom_range(0, 1) == 0);
      ex_bus = mk_bus($urandom, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
                      req & 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), req);
      wb_allow_in = ($urandom_range(0, 3) != 0);
      rdata = $urandom;
      data_ok = outstanding() ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
      resetn = ($urandom_range(0, 499) != 0);
      step();
    end
    resetn = 1'b1;
    idle_inputs();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/me_stage.md
ME_STAGE -- requirements
Module: me_stage

Interface
REQ-001 Parameters: none; all widths fixed.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 resetn  in  1  asynchronous, active-low reset.
REQ-004 EX_to_ME_Valid  in  1  EX holds a valid instruction for ME.
REQ-005 EX_to_ME_Bus  in  75  {pc[74:43], gr_we[42], dest[41:37], alu_result[36:5], res_from_mem[4], mem_op[3:1], mem_req[0]}.
REQ-006 ME_Allow_in  out  1  ME accepts the bus this cycle.
REQ-007 WB_Allow_in  in  1  WB accepts ME output this cycle.
REQ-008 ME_to_WB_Valid  out  1  ME output valid for WB.
REQ-009 ME_to_WB_Bus  out  70  {pc[69:38], gr_we[37], dest[36:32], final_result[31:0]}.
REQ-010 data_sram_data_ok  in  1  one-cycle pulse: response for request issued by EX.
REQ-011 data_sram_rdata  in  32  read data, valid only with data_sram_data_ok.
REQ-012 ME_dest  out  5  forwarding destination, 0 when no write pending.
REQ-013 ME_Forward_Res  out  32  forwarding value (final_result).
REQ-014 ME_Load_Busy  out  1  load in ME without data yet; upstream interlock.

Function
REQ-015 Bus fields latch on EX_to_ME_Valid && ME_Allow_in; ME_Valid <= EX_to_ME_Valid when ME_Allow_in.
REQ-016 ME_Allow_in = !ME_Valid || (ME_ReadyGo && WB_Allow_in); ME_to_WB_Valid = ME_Valid && ME_ReadyGo.
REQ-017 State machine IDLE/WAIT/HOLD tracks the memory response of the instruction held in ME.
REQ-018 Accept with mem_req=1 -> WAIT; accept with mem_req=0, or no accept while leaving -> IDLE.
REQ-019 WAIT: data_ok && WB_Allow_in -> instruction leaves; next state per REQ-018 for any simultaneous accept.
REQ-020 WAIT: data_ok && !WB_Allow_in -> capture rdata into hold buffer, go HOLD.
REQ-021 HOLD: WB_Allow_in -> leaves; next state per REQ-018; otherwise stay HOLD, buffer unchanged.
REQ-022 ME_ReadyGo = (ME_Valid && !mem_req) || (state==WAIT && data_ok) || state==HOLD.
REQ-023 Load data source: hold buffer in HOLD, else live data_sram_rdata.
REQ-024 mem_op: 000 ld.b, 001 ld.h, 010 ld.w, 100 ld.bu, 101 ld.hu; other codes treated as ld.w.
REQ-025 Byte select by alu_result[1:0], half select by alu_result[1]; .b/.h sign-extend, .bu/.hu zero-extend to 32.
REQ-026 final_result = aligned load data if res_from_mem else alu_result.
REQ-027 Stores (mem_req=1, res_from_mem=0) also wait for data_ok; final_result = alu_result.
REQ-028 data_ok in IDLE or HOLD is ignored; no state or data change.
REQ-029 ME_dest = dest & {5{gr_we && ME_Valid}}; ME_Forward_Res = final_result, combinational.
REQ-030 ME_Load_Busy = ME_Valid && res_from_mem && !ME_ReadyGo.
REQ-031 Zero added latency when no memory access: accept cycle N, valid to WB in cycle N+1.

Reset
REQ-032 resetn=0 immediately clears ME_Valid, state=IDLE, hold buffer=0; ME_to_WB_Valid=0, ME_Load_Busy=0, ME_dest=0.
REQ-033 Reset mid-WAIT/HOLD drops the instruction; a data_ok arriving later in IDLE is ignored.
REQ-034 Bus payload registers need no reset; outputs gated by ME_Valid where specified.

Verification
REQ-035 ALU op pc=0x1C000000, dest=5, alu_result=0x12345678, gr_we=1 -> next cycle ME_to_WB_Bus={0x1C000000,1,5,0x12345678}, ME_dest=5.
REQ-036 ld.b addr low bits 2'b11, rdata=0x80FF00AA, data_ok after 2 cycles -> ME_Load_Busy=1 for 2 cycles, then final_result=0xFFFFFF80.
REQ-037 ld.hu addr[1]=1, rdata=0x8001_7FFF, data_ok with WB_Allow_in=0 -> HOLD; WB_Allow_in=1 two cycles later -> final_result=0x00008001, rdata changes ignored.
REQ-038 Store, gr_we=0 -> waits data_ok, ME_dest=0 throughout, forwarded to WB with final_result=alu_result.
REQ-039 Back-to-back loads, second accepted same cycle first leaves on data_ok -> state stays WAIT, no data reuse.
REQ-040 resetn low during WAIT, stray data_ok after release -> ME_to_WB_Valid stays 0, state IDLE.
